result_fifo: RTL and testbench

RESULT_FIFO -- requirements
Module: result_fifo

---
 rtl/result_fifo_pkg.sv | 14 +
 rtl/fifo_mem.sv | 29 ++
 rtl/result_fifo.sv | 91 +++++++++
 tb/tb_result_fifo.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/result_fifo_pkg.sv
// Shared constants for the result FIFO: default geometry and FSM state encoding.
package result_fifo_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 4;

  // Occupancy state; the encoding is visible on the state output.
  typedef enum logic [1:0] {
    ST_EMPTY   = 2'b00,
    ST_PARTIAL = 2'b01,
    ST_FULL    = 2'b10
  } state_t;

endpackage

// File: rtl/fifo_mem.sv
// Storage array for the result FIFO.
// One synchronous write port and one asynchronous read port. There is no reset,
// because valid entries are tracked entirely by the pointers and count.
module fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write the addressed entry on an accepted push.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // The read is combinational, so the head entry appears as soon as it is written.
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/result_fifo.sv
// Result FIFO that buffers words from the logic stage for a downstream consumer.
//
// Handshake: a word moves across an interface on a rising edge exactly when
// valid and ready are both 1 on that interface. The producer must hold in_data
// and in_valid stable until it sees in_ready. in_ready depends only on state
// and does not depend on out_ready, so a full FIFO refuses a push even when the
// same edge pops a word. out_valid depends only on state, so there is no
// same-cycle bypass.
module result_fifo
  import result_fifo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic [1:0]               state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;

  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Compute the next pointers, count and occupancy state.
  // Pointers are exactly AW bits wide, so they wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    state_d  = state_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop) begin
      count_d = count_q + CW'(1);
      state_d = (count_q == CW'(DEPTH - 1)) ? ST_FULL : ST_PARTIAL;
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
      state_d = (count_q == CW'(1)) ? ST_EMPTY : ST_PARTIAL;
    end
  end

  // Register the FSM, pointers and count. Reset is asynchronous and discards all
  // stored words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_EMPTY;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count = count_q;
  assign state = state_q;

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (in_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (out_data)
  );

endmodule

// File: tb/tb_result_fifo.sv
// Bench for result_fifo: directed scenarios followed by random traffic.
// A queue-based reference model predicts every output.
module tb_result_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [2:0]       count;
  logic [1:0]       state;

  always #5 clk = ~clk;

  result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .state     (state)
  );

  // ---------------- scoreboard ----------------
  logic [WIDTH-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every output with the prediction from the model queue.
  task automatic check_all(input string tag);
    logic [1:0] exp_state;
    int n;
    n = exp_q.size();
    exp_state = (n == 0) ? 2'b00 : (n == DEPTH) ? 2'b10 : 2'b01;
    chk({tag, ".count"},     32'(count),     32'(n));
    chk({tag, ".state"},     32'(state),     32'(exp_state));
    chk({tag, ".in_ready"},  32'(in_ready),  32'(n != DEPTH));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(n != 0));
    if (n != 0) chk({tag, ".out_data"}, 32'(out_data), 32'(exp_q[0]));
  endtask

  // ---------------- driver ----------------
  // Advance one edge and apply the FIFO rules to the model.
  // The outputs are then checked 1 time unit after the edge.
  task automatic cycle(input string tag);
    bit do_push, do_pop;
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
    end else begin
      do_push = in_valid && (exp_q.size() < DEPTH);
      do_pop  = out_ready && (exp_q.size() > 0);
      if (do_pop)  void'(exp_q.pop_front());
      if (do_push) exp_q.push_back(in_data);
    end
    #1;
    check_all(tag);
  endtask

  task automatic push_word(input logic [WIDTH-1:0] d, input string tag);
    in_data  = d;
    in_valid = 1'b1;
    cycle(tag);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle("rst_a");
    cycle("rst_b");
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [WIDTH-1:0] fill_tab [4];
  logic [WIDTH-1:0] nxt;

  initial begin
    fill_tab[0] = 8'h00; fill_tab[1] = 8'hFF; fill_tab[2] = 8'hAA; fill_tab[3] = 8'h0F;
    rst = 1'b1; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;

    // Reset, then release between edges.
    do_reset();
    chk("rst.count", 32'(count), 32'd0);
    chk("rst.state", 32'(state), 32'd0);
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.out_valid", 32'(out_valid), 32'd0);

    // Single word, accepted on the first edge after release.
    push_word(8'b11110000, "single");
    chk("single.data", 32'(out_data), 32'hF0);
    chk("single.state", 32'(state), 32'd1);

    // Fill from a fresh reset so the pointers start at index 0.
    do_reset();
    for (int i = 0; i < 4; i++) push_word(fill_tab[i], "fill");
    chk("fill.state", 32'(state), 32'd2);
    chk("fill.in_ready", 32'(in_ready), 32'd0);
    in_data = 8'h55; in_valid = 1'b1;
    cycle("hold1");
    cycle("hold2");
    chk("hold.count", 32'(count), 32'd4);
    in_valid = 1'b0;

    // Drain and wrap.
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain.data", 32'(out_data), 32'(fill_tab[i]));
      cycle("drain");
    end
    out_ready = 1'b0;
    chk("drain.state", 32'(state), 32'd0);
    push_word(8'hA0, "wrap");
    chk("wrap.data", 32'(out_data), 32'hA0);

    // Simultaneous push and pop at count=2.
    push_word(8'h10, "sim_pre");
    nxt = 8'h20;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_data = nxt;
      cycle("sim");
      chk("sim.count", 32'(count), 32'd2);
      nxt = nxt + 8'h01;
    end
    in_valid = 1'b0;
    cycle("sim_drain1");
    cycle("sim_drain2");
    out_ready = 1'b0;

    // Reset in mid-operation, asserted between edges.
    for (int i = 0; i < 3; i++) push_word(8'(8'h30 + i), "mid_fill");
    #3;
    rst = 1'b1;
    #1;
    exp_q.delete();
    chk("mid.count", 32'(count), 32'd0);
    chk("mid.out_valid", 32'(out_valid), 32'd0);
    chk("mid.state", 32'(state), 32'd0);
    cycle("mid_rst");
    rst = 1'b0;
    push_word(8'h3C, "mid_push");
    chk("mid.data", 32'(out_data), 32'h3C);

    // Random traffic against the model.
    for (int i = 0; i < 300; i++) begin
      in_data   = 8'($urandom);
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0) ? 1'b0 : 1'b1;
      if (i > 150) out_ready = 1'($urandom_range(0, 1));
      cycle("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
